// File: rtl/demux1_2_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2_stream_pkg
//  Description : Shared constants and types for the 1-to-2 stream demux.
//                Default widths match the mux2_1 family.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux1_2_stream_pkg;

    // Per-beat destination encoding
    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    // Default widths, shared with the mux2_1 family
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    // Holding-slot occupancy; the encoding doubles as the valid flag
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : demux1_2_stream_pkg
`default_nettype wire

// File: rtl/demux1_2_stream_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2_stream_slot
//  Description : One output channel of the demux: a single-entry holding
//                slot with valid/ready drain and a wrapping delivered-beat
//                counter with synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1_2_stream_slot
    import demux1_2_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_state_e r_state;
    slot_state_e w_state_next;
    logic        w_drain;

    assign valid   = (r_state == SLOT_FULL);
    assign w_drain = valid & ready;

    // Slot occupancy register; reset discards any held beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy: a load always leaves the slot full, even with a drain
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (load) begin
                    w_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (w_drain && !load) begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            default: w_state_next = SLOT_EMPTY;
        endcase
    end

    // Beat register; only written on load so data stays stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Delivered-beat counter, wraps naturally; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (w_drain) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule : demux1_2_stream_slot
`default_nettype wire

// File: rtl/demux1_2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux1_2_stream
//  Description : Registered 1-to-2 stream demultiplexer with valid/ready
//                handshakes. Each beat is steered by in_sel into one of two
//                single-entry output slots, each with a delivered-beat count.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1_2_stream
    import demux1_2_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic w_accept;
    logic w_load0;
    logic w_load1;

    // Ready depends only on the selected slot; no path from in_valid
    always_comb begin
        in_ready = 1'b0;
        if (in_sel == SEL_OUT0) begin
            in_ready = !out0_valid || out0_ready;
        end else begin
            in_ready = !out1_valid || out1_ready;
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_load0  = w_accept & (in_sel == SEL_OUT0);
    assign w_load1  = w_accept & (in_sel == SEL_OUT1);

    demux1_2_stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load0),
        .load_data (in_data),
        .ready     (out0_ready),
        .clr_cnt   (clr_cnt),
        .data      (out0_data),
        .valid     (out0_valid),
        .cnt       (cnt0)
    );

    demux1_2_stream_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .clr_cnt   (clr_cnt),
        .data      (out1_data),
        .valid     (out1_valid),
        .cnt       (cnt1)
    );

endmodule : demux1_2_stream
`default_nettype wire

// File: tb/tb_demux1_2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1_2_stream
//  Description : Self-checking bench for demux1_2_stream. A queue-based
//                reference (per-channel FIFO of accepted, undelivered beats
//                plus delivered counts) predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_2_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic       clr_cnt;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    demux1_2_stream #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .clr_cnt    (clr_cnt),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    // Reference state: beats accepted but not yet delivered, per channel
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [7:0] m_cnt0;
    logic [7:0] m_cnt1;
    logic       stalled;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (called at negedge), check every output
    // against the reference mid-phase, then advance the reference.
    task automatic cycle(input logic v, input logic s, input logic [3:0] d,
                         input logic r0, input logic r1, input logic clr);
        logic e_v0, e_v1, e_rdy;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        clr_cnt    = clr;
        #1;
        e_v0 = (q0.size() != 0);
        e_v1 = (q1.size() != 0);
        check("out0_valid", {31'd0, out0_valid}, {31'd0, e_v0});
        check("out1_valid", {31'd0, out1_valid}, {31'd0, e_v1});
        if (e_v0) check("out0_data", {28'd0, out0_data}, {28'd0, q0[0]});
        if (e_v1) check("out1_data", {28'd0, out1_data}, {28'd0, q1[0]});
        check("cnt0", {24'd0, cnt0}, {24'd0, m_cnt0});
        check("cnt1", {24'd0, cnt1}, {24'd0, m_cnt1});
        e_rdy = s ? (!e_v1 || r1) : (!e_v0 || r0);
        check("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
        stalled = v && !e_rdy;
        if (e_v0 && r0) begin
            void'(q0.pop_front());
            m_cnt0 = m_cnt0 + 8'd1;
        end
        if (e_v1 && r1) begin
            void'(q1.pop_front());
            m_cnt1 = m_cnt1 + 8'd1;
        end
        if (clr) begin
            m_cnt0 = 8'd0;
            m_cnt1 = 8'd0;
        end
        if (v && e_rdy) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting at a negedge
    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out0_data", {28'd0, out0_data}, 32'd0);
        check("rst_out1_data", {28'd0, out1_data}, 32'd0);
        check("rst_cnt0", {24'd0, cnt0}, 32'd0);
        check("rst_cnt1", {24'd0, cnt1}, 32'd0);
        q0.delete();
        q1.delete();
        m_cnt0 = 8'd0;
        m_cnt1 = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic       v, s, r0, r1, clr;
        logic [3:0] d;
        clk        = 1'b0;
        rst_n      = 1'b1;
        in_data    = 4'd0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        clr_cnt    = 1'b0;
        n_checks   = 0;
        n_errors   = 0;
        stalled    = 1'b0;
        m_cnt0     = 8'd0;
        m_cnt1     = 8'd0;
        @(negedge clk);
        do_reset();

        // Reset mid-stream: fill both slots, then reset
        cycle(1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Steering with both consumers ready
        cycle(1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("steer_cnt0", {24'd0, cnt0}, 32'd1);
        check("steer_cnt1", {24'd0, cnt1}, 32'd1);

        // Backpressure on channel 0 while channel 1 proceeds
        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);

        // Full throughput: 16 back-to-back beats on channel 0
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 4'(i), 1'b1, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("thru_cnt0", {24'd0, cnt0}, 32'd16);

        // Counter wrap: 256 beats on channel 1
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("wrap_cnt1", {24'd0, cnt1}, 32'd0);

        // Clear coincident with a drain: clear wins
        cycle(1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("clr_over_inc", {24'd0, cnt0}, 32'd0);

        // Random traffic; upstream holds its beat while stalled
        v = 1'b0; s = 1'b0; d = 4'h0;
        for (int i = 0; i < 10000; i++) begin
            if (!stalled) begin
                v = ($urandom % 3) != 0;
                s = 1'($urandom);
                d = 4'($urandom);
            end
            r0  = ($urandom % 4) != 0;
            r1  = ($urandom % 3) != 0;
            clr = ($urandom % 97) == 0;
            cycle(v, s, d, r0, r1, clr);
        end
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("final_empty0", {31'd0, out0_valid}, 32'd0);
        check("final_empty1", {31'd0, out1_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_demux1_2_stream
`default_nettype wire
